// File: rtl/ni_flit_injector_if.sv
// Node-side and router-side signal bundle of the flit injector.
// The slave modport is the injector; the master modport is its environment
// (the node that supplies packets plus the router that returns credits).
interface ni_flit_injector_if #(
  parameter int num_vcs            = 4,
  parameter int credits_per_vc     = 8,
  parameter int flit_data_width    = 64,
  parameter int max_payload_length = 4
);
  localparam int vc_idx_width    = (num_vcs > 1) ? $clog2(num_vcs) : 1;
  localparam int len_width       = $clog2(max_payload_length + 1);
  localparam int channel_width   = 3 + vc_idx_width + flit_data_width;
  localparam int flow_ctrl_width = 1 + vc_idx_width;

  logic                       pkt_valid;
  logic                       pkt_ready;
  logic [vc_idx_width-1:0]    pkt_vc;
  logic [len_width-1:0]       pkt_length;
  logic [flit_data_width-1:0] pkt_header;
  logic                       pay_valid;
  logic                       pay_ready;
  logic [flit_data_width-1:0] pay_data;
  logic [channel_width-1:0]   channel_out;
  logic [flow_ctrl_width-1:0] flow_ctrl_in;

  modport master (
    output pkt_valid, pkt_vc, pkt_length, pkt_header,
    output pay_valid, pay_data, flow_ctrl_in,
    input  pkt_ready, pay_ready, channel_out
  );

  modport slave (
    input  pkt_valid, pkt_vc, pkt_length, pkt_header,
    input  pay_valid, pay_data, flow_ctrl_in,
    output pkt_ready, pay_ready, channel_out
  );
endinterface

// File: rtl/ni_flit_injector.sv
// Network-interface injector: turns packet descriptors plus payload beats
// into head/body/tail flits on one router input channel, with per-VC
// credit tracking so the router input buffers are never overrun.
//
// state | meaning
// IDLE  | waiting for a descriptor; head flit emitted on accept
// BODY  | emitting payload flits of the current packet on cur_vc
module ni_flit_injector #(
  parameter int num_vcs            = 4,
  parameter int credits_per_vc     = 8,
  parameter int flit_data_width    = 64,
  parameter int max_payload_length = 4
) (
  input  logic              clk,
  input  logic              reset,
  ni_flit_injector_if.slave bus,
  output logic              idle,
  output logic              error
);
  localparam int vc_idx_width = (num_vcs > 1) ? $clog2(num_vcs) : 1;
  localparam int len_width    = $clog2(max_payload_length + 1);
  localparam int cnt_width    = $clog2(credits_per_vc + 1);

  localparam logic [cnt_width-1:0] credit_full = cnt_width'(credits_per_vc);
  localparam logic [len_width-1:0] max_len     = len_width'(max_payload_length);
  localparam logic [len_width-1:0] len_one     = len_width'(1);

  typedef enum logic {IDLE, BODY} state_t;

  state_t                  state;
  logic [cnt_width-1:0]    credit      [num_vcs];
  logic [cnt_width-1:0]    credit_next [num_vcs];
  logic [vc_idx_width-1:0] cur_vc;
  logic [len_width-1:0]    remaining;

  logic                    fc_valid;
  logic [vc_idx_width-1:0] fc_vc;
  logic                    pkt_fire;
  logic                    pkt_bad;
  logic                    head_fire;
  logic                    beat_fire;
  logic                    send_valid;
  logic [vc_idx_width-1:0] send_vc;
  logic                    overflow;
  logic                    all_full_next;
  logic                    to_idle;

  assign {fc_valid, fc_vc} = bus.flow_ctrl_in;

  // Ready signals; pkt_ready is also gated by reset so it reads 0 while
  // reset is held, even though the FSM already sits in IDLE.
  always_comb begin
    bus.pkt_ready = reset && (state == IDLE) && !error &&
                    (credit[bus.pkt_vc] != '0);
    bus.pay_ready = (state == BODY) && (credit[cur_vc] != '0);
  end

  // Accept decode and the VC charged for the flit sent this cycle.
  always_comb begin
    pkt_fire   = bus.pkt_valid && bus.pkt_ready;
    pkt_bad    = bus.pkt_length > max_len;
    head_fire  = pkt_fire && !pkt_bad;
    beat_fire  = bus.pay_valid && bus.pay_ready;
    send_valid = head_fire || beat_fire;
    send_vc    = head_fire ? bus.pkt_vc : cur_vc;
    if (state == IDLE) to_idle = !(head_fire && (bus.pkt_length != '0));
    else               to_idle = beat_fire && (remaining == len_one);
  end

  // Next credit values: a send and a return on the same VC cancel out; a
  // return into a full counter saturates and flags an overflow.
  always_comb begin
    overflow      = 1'b0;
    all_full_next = 1'b1;
    for (int i = 0; i < num_vcs; i++) begin
      credit_next[i] = credit[i];
      if (send_valid && (send_vc == i[vc_idx_width-1:0]) &&
          !(fc_valid && (fc_vc == i[vc_idx_width-1:0]))) begin
        credit_next[i] = credit[i] - 1'b1;
      end else if (fc_valid && (fc_vc == i[vc_idx_width-1:0]) &&
                   !(send_valid && (send_vc == i[vc_idx_width-1:0]))) begin
        if (credit[i] == credit_full) overflow = 1'b1;
        else                          credit_next[i] = credit[i] + 1'b1;
      end
      if (credit_next[i] != credit_full) all_full_next = 1'b0;
    end
  end

  // Packet FSM with registered flit output, credits and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cur_vc          <= '0;
      remaining       <= '0;
      bus.channel_out <= '0;
      error           <= 1'b0;
      idle            <= 1'b1;
      for (int i = 0; i < num_vcs; i++) credit[i] <= credit_full;
    end else begin
      for (int i = 0; i < num_vcs; i++) credit[i] <= credit_next[i];
      idle            <= to_idle && all_full_next;
      bus.channel_out <= '0;
      if (overflow || (pkt_fire && pkt_bad)) error <= 1'b1;
      case (state)
        IDLE: begin
          if (head_fire) begin
            bus.channel_out <= {1'b1, bus.pkt_vc, 1'b1,
                                (bus.pkt_length == '0), bus.pkt_header};
            cur_vc          <= bus.pkt_vc;
            remaining       <= bus.pkt_length;
            if (bus.pkt_length != '0) state <= BODY;
          end
        end
        BODY: begin
          if (beat_fire) begin
            bus.channel_out <= {1'b1, cur_vc, 1'b0,
                                (remaining == len_one), bus.pay_data};
            remaining       <= remaining - len_one;
            if (remaining == len_one) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ni_flit_injector.sv
// Self-checking bench for ni_flit_injector: a vector table for the basic
// packet flow, directed sequences for multi-cycle corners, and a random
// phase compared against a credit/packet model.
module tb_ni_flit_injector;
  logic clk;
  logic reset;
  logic idle;
  logic error;
  int   total = 0;
  int   bad   = 0;

  ni_flit_injector_if bus ();

  ni_flit_injector dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .idle  (idle),
    .error (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [1:0]  vc;
    logic [2:0]  len;
    logic [63:0] hdr;
    logic        yv;
    logic [63:0] yd;
    logic        fcv;
    logic [1:0]  fcvc;
    logic        e_pr;
    logic        e_yr;
    logic [68:0] e_ch;
    logic        e_idle;
    logic        e_err;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [68:0] flit(input int vc, input bit h, input bit t,
                                       input logic [63:0] d);
    logic [1:0] v;
    v = vc[1:0];
    return {1'b1, v, h, t, d};
  endfunction

  function automatic vec_t mk(input bit pv, input int vc, input int len,
                              input logic [63:0] hdr, input bit yv,
                              input logic [63:0] yd, input bit fcv,
                              input int fcvc, input bit e_pr, input bit e_yr,
                              input logic [68:0] e_ch, input bit e_idle,
                              input bit e_err);
    vec_t r;
    r.pv = pv; r.vc = vc[1:0]; r.len = len[2:0]; r.hdr = hdr;
    r.yv = yv; r.yd = yd; r.fcv = fcv; r.fcvc = fcvc[1:0];
    r.e_pr = e_pr; r.e_yr = e_yr; r.e_ch = e_ch;
    r.e_idle = e_idle; r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input bit pv, input int vc, input int len,
                        input logic [63:0] hdr, input bit yv,
                        input logic [63:0] yd, input bit fcv, input int fcvc);
    bus.pkt_valid    = pv;
    bus.pkt_vc       = vc[1:0];
    bus.pkt_length   = len[2:0];
    bus.pkt_header   = hdr;
    bus.pay_valid    = yv;
    bus.pay_data     = yd;
    bus.flow_ctrl_in = {fcv, fcvc[1:0]};
  endtask

  task automatic clear_in();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Count how many zero-length packets a VC accepts back-to-back.
  task automatic drain(input int vc, output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      set_in(1, vc, 0, 64'h0, 0, 0, 0, 0);
      #1;
      if (!bus.pkt_ready) break;
      n++;
      tick();
    end
    clear_in();
    tick();
  endtask

  // Reference model state for the random phase.
  int cred[4];
  int rem;
  int cvc;
  bit merr;

  initial begin
    int n;
    int flits;
    logic [68:0] last_ch;

    reset = 1'b1;
    clear_in();
    #1 reset = 1'b0;
    set_in(1, 0, 0, 64'h1, 1, 0, 0, 0);
    #1;
    chk("rst_pkt_ready", bus.pkt_ready, 0);
    chk("rst_pay_ready", bus.pay_ready, 0);
    chk("rst_channel",   bus.channel_out, 0);
    chk("rst_error",     error, 0);
    chk("rst_idle",      idle, 1);
    do_reset();

    // Table: single packet on VC 2, credit returns, zero-length packets.
    tbl[0]  = mk(1, 2, 3, 64'hA5, 0, 0,  0, 0, 1, 0, flit(2, 1, 0, 64'hA5), 0, 0);
    tbl[1]  = mk(0, 0, 0, 0,      1, 1,  0, 0, 0, 1, flit(2, 0, 0, 64'h1), 0, 0);
    tbl[2]  = mk(0, 0, 0, 0,      1, 2,  0, 0, 0, 1, flit(2, 0, 0, 64'h2), 0, 0);
    tbl[3]  = mk(0, 0, 0, 0,      1, 3,  0, 0, 0, 1, flit(2, 0, 1, 64'h3), 0, 0);
    tbl[4]  = mk(0, 0, 0, 0,      0, 0,  1, 2, 1, 0, 69'h0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0,      0, 0,  1, 2, 1, 0, 69'h0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0,      0, 0,  1, 2, 1, 0, 69'h0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0,      0, 0,  1, 2, 1, 0, 69'h0, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0,      1, 99, 0, 0, 1, 0, 69'h0, 1, 0);
    tbl[9]  = mk(1, 1, 0, 64'h11, 0, 0,  0, 0, 1, 0, flit(1, 1, 1, 64'h11), 0, 0);
    tbl[10] = mk(1, 3, 0, 64'h22, 0, 0,  1, 1, 1, 0, flit(3, 1, 1, 64'h22), 0, 0);
    tbl[11] = mk(0, 0, 0, 0,      0, 0,  1, 3, 1, 0, 69'h0, 1, 0);
    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].pv, tbl[i].vc, tbl[i].len, tbl[i].hdr, tbl[i].yv,
             tbl[i].yd, tbl[i].fcv, tbl[i].fcvc);
      #1;
      chk($sformatf("tbl%0d_pkt_ready", i), bus.pkt_ready, tbl[i].e_pr);
      chk($sformatf("tbl%0d_pay_ready", i), bus.pay_ready, tbl[i].e_yr);
      tick();
      chk($sformatf("tbl%0d_channel", i), bus.channel_out, tbl[i].e_ch);
      chk($sformatf("tbl%0d_idle", i), idle, tbl[i].e_idle);
      chk($sformatf("tbl%0d_error", i), error, tbl[i].e_err);
    end
    clear_in();

    // Credit exhaustion on VC 0, then a return in cycle N enables N+1.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_in(1, 0, 0, 64'(i), 0, 0, 0, 0);
      #1;
      chk($sformatf("exh_ready%0d", i), bus.pkt_ready, 1);
      tick();
      chk($sformatf("exh_flit%0d", i), bus.channel_out, flit(0, 1, 1, 64'(i)));
    end
    set_in(1, 0, 0, 64'h9, 0, 0, 0, 0);
    #1;
    chk("exh_ready9_blocked", bus.pkt_ready, 0);
    tick();
    chk("exh_no_flit", bus.channel_out, 0);
    set_in(1, 0, 0, 64'h9, 0, 0, 1, 0);
    #1;
    chk("exh_ready_cycle_n", bus.pkt_ready, 0);
    tick();
    set_in(1, 0, 0, 64'h9, 0, 0, 0, 0);
    #1;
    chk("exh_ready_cycle_n1", bus.pkt_ready, 1);
    tick();
    chk("exh_flit9", bus.channel_out, flit(0, 1, 1, 64'h9));
    clear_in();

    // Stall mid-packet: VC 1 left with 2 credits, 4-beat payload.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_in(1, 1, 0, 0, 0, 0, 0, 0);
      tick();
    end
    flits = 0;
    set_in(1, 1, 4, 64'hB0, 0, 0, 0, 0);
    tick();
    chk("stall_head", bus.channel_out, flit(1, 1, 0, 64'hB0));
    set_in(0, 0, 0, 0, 1, 64'hB1, 0, 0);
    #1;
    chk("stall_beat1_ready", bus.pay_ready, 1);
    tick();
    chk("stall_beat1", bus.channel_out, flit(1, 0, 0, 64'hB1));
    set_in(0, 0, 0, 0, 1, 64'hB2, 0, 0);
    #1;
    chk("stall_blocked", bus.pay_ready, 0);
    tick();
    chk("stall_no_flit", bus.channel_out, 0);
    set_in(0, 0, 0, 0, 1, 64'hB2, 1, 1);
    tick();
    set_in(0, 0, 0, 0, 1, 64'hB2, 1, 1);
    #1;
    chk("stall_resume_ready", bus.pay_ready, 1);
    tick();
    chk("stall_beat2", bus.channel_out, flit(1, 0, 0, 64'hB2));
    set_in(0, 0, 0, 0, 1, 64'hB3, 1, 1);
    tick();
    chk("stall_beat3", bus.channel_out, flit(1, 0, 0, 64'hB3));
    flits = 4;
    for (int k = 0; k < 5 && flits < 5; k++) begin
      set_in(0, 0, 0, 0, 1, 64'hB4, 0, 0);
      tick();
      if (bus.channel_out[66]) begin
        flits++;
        last_ch = bus.channel_out;
      end
    end
    chk("stall_flit_count", flits, 5);
    chk("stall_tail", last_ch, flit(1, 0, 1, 64'hB4));
    clear_in();

    // Same-VC send and return at count 3 leaves 3 credits.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    set_in(1, 0, 0, 64'h5, 0, 0, 1, 0);
    tick();
    chk("same_vc_flit", bus.channel_out, flit(0, 1, 1, 64'h5));
    clear_in();
    drain(0, n);
    chk("same_vc_credits", n, 3);

    // Send on VC 0 with return on VC 1 in the same cycle.
    do_reset();
    set_in(1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 1, 1);
    tick();
    chk("cross_idle", idle, 0);
    clear_in();
    drain(0, n);
    chk("cross_vc0_credits", n, 7);
    drain(1, n);
    chk("cross_vc1_credits", n, 8);

    // Overflow on a full VC 3.
    do_reset();
    set_in(0, 3, 0, 0, 0, 0, 1, 3);
    tick();
    chk("ovf_error", error, 1);
    chk("ovf_idle_full", idle, 1);
    set_in(1, 3, 0, 0, 0, 0, 0, 0);
    #1;
    chk("ovf_pkt_ready", bus.pkt_ready, 0);
    tick();
    chk("ovf_no_flit", bus.channel_out, 0);
    clear_in();

    // Oversized descriptor is consumed without a flit.
    do_reset();
    set_in(1, 0, 5, 64'hEE, 0, 0, 0, 0);
    #1;
    chk("bad_len_ready", bus.pkt_ready, 1);
    tick();
    chk("bad_len_no_flit", bus.channel_out, 0);
    chk("bad_len_error", error, 1);
    chk("bad_len_idle", idle, 1);
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("bad_len_ready_after", bus.pkt_ready, 0);
    clear_in();

    // Async reset in the middle of a packet that has also flagged an error.
    do_reset();
    set_in(1, 2, 3, 64'hC0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 1, 64'hC1, 1, 3);
    tick();
    chk("arst_err_set", error, 1);
    set_in(0, 0, 0, 0, 1, 64'hC2, 0, 0);
    #1;
    chk("arst_body_continues", bus.pay_ready, 1);
    tick();
    chk("arst_pre_flit", bus.channel_out, flit(2, 0, 0, 64'hC2));
    set_in(1, 0, 0, 0, 1, 64'hC3, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("arst_channel", bus.channel_out, 0);
    chk("arst_error", error, 0);
    chk("arst_pkt_ready", bus.pkt_ready, 0);
    chk("arst_pay_ready", bus.pay_ready, 0);
    clear_in();
    #2 reset = 1'b1;
    tick();
    for (int v = 0; v < 4; v++) begin
      drain(v, n);
      chk($sformatf("arst_credits_vc%0d", v), n, 8);
    end

    // Random traffic against the model.
    do_reset();
    for (int v = 0; v < 4; v++) cred[v] = 8;
    rem = 0; cvc = 0; merr = 0;
    for (int c = 0; c < 1500; c++) begin
      bit pv, yv, fcv, e_pr, e_yr, e_idle;
      int vc, len, fcvc;
      logic [63:0] hdr, yd;
      logic [68:0] e_ch;
      pv   = ($urandom_range(0, 2) != 0);
      vc   = $urandom_range(0, 3);
      len  = $urandom_range(0, 4);
      hdr  = {$urandom, $urandom};
      yv   = ($urandom_range(0, 3) != 0);
      yd   = {$urandom, $urandom};
      fcvc = $urandom_range(0, 3);
      fcv  = (cred[fcvc] < 8) && ($urandom_range(0, 2) == 0);
      set_in(pv, vc, len, hdr, yv, yd, fcv, fcvc);
      e_pr = (rem == 0) && !merr && (cred[vc] > 0);
      e_yr = (rem > 0) && (cred[cvc] > 0);
      e_ch = '0;
      if (pv && e_pr) begin
        e_ch = flit(vc, 1, len == 0, hdr);
        cred[vc]--;
        rem = len;
        cvc = vc;
      end else if (yv && e_yr) begin
        e_ch = flit(cvc, 0, rem == 1, yd);
        cred[cvc]--;
        rem--;
      end
      if (fcv) cred[fcvc]++;
      e_idle = (rem == 0);
      for (int v = 0; v < 4; v++) if (cred[v] != 8) e_idle = 0;
      #1;
      chk("rnd_pkt_ready", bus.pkt_ready, e_pr);
      chk("rnd_pay_ready", bus.pay_ready, e_yr);
      tick();
      chk("rnd_channel", bus.channel_out, e_ch);
      chk("rnd_idle", idle, e_idle);
      chk("rnd_error", error, merr);
    end
    clear_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
